// File: rtl/uart_core_param.sv
// uart_core_param: parametrised single-clock full-duplex UART.
// TX accepts words over valid/ready and serialises start/data/[parity]/stop.
// RX synchronises the line, samples each bit mid-period and reports errors.
//
// Handshake: a word is transferred on a rising clk edge where tx_valid and
// tx_ready are both high. tx_ready is high only while TX is idle and rst is
// low. tx_data may change after the transfer edge. rx_valid is a one-cycle
// pulse with no back-pressure; the error flags are meaningful only while
// rx_valid is high and read 0 otherwise.
module uart_core_param #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     clk_div,
  input  logic                 loopback,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 Tx_Serial,
  output logic                 Tx_Active,
  input  logic                 Rx_Serial,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic [2:0]           tx_state_dbg,
  output logic [2:0]           rx_state_dbg
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------- TX
  state_t                 tx_state, tx_next;
  logic [DIV_W-1:0]       tx_cnt;
  logic [IDX_W-1:0]       tx_idx;
  logic                   tx_stop_idx;
  logic [DATA_BITS-1:0]   tx_shreg;
  logic                   tx_line;
  logic                   tx_tick;
  logic                   tx_par_bit;

  assign tx_tick    = (tx_cnt == '0);
  assign tx_par_bit = (PARITY == 2) ? ~(^tx_shreg) : ^tx_shreg;

  // TX state register
  always_ff @(posedge clk) begin
    if (rst) tx_state <= S_IDLE;
    else     tx_state <= tx_next;
  end

  // TX next-state: each bit ends when the down-counter reaches zero
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:   if (tx_valid) tx_next = S_START;
      S_START:  if (tx_tick) tx_next = S_DATA;
      S_DATA:   if (tx_tick && tx_idx == LAST_IDX)
                  tx_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tx_tick) tx_next = S_STOP;
      S_STOP:   if (tx_tick && tx_stop_idx == LAST_STOP) tx_next = S_IDLE;
      default:  tx_next = S_IDLE;
    endcase
  end

  // TX datapath: word latch, bit counter and bit index
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_stop_idx <= 1'b0;
      tx_shreg    <= '0;
    end else if (tx_state == S_IDLE) begin
      if (tx_valid) begin
        tx_shreg    <= tx_data;
        tx_cnt      <= clk_div;
        tx_idx      <= '0;
        tx_stop_idx <= 1'b0;
      end
    end else if (tx_tick) begin
      tx_cnt <= clk_div;
      if (tx_state == S_DATA) tx_idx <= tx_idx + 1'b1;
      if (tx_state == S_STOP) tx_stop_idx <= tx_stop_idx + 1'b1;
    end else begin
      tx_cnt <= tx_cnt - 1'b1;
    end
  end

  // TX outputs: line level per state, pin forced high in reset or loopback
  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      S_START:  tx_line = 1'b0;
      S_DATA:   tx_line = tx_shreg[tx_idx];
      S_PARITY: tx_line = tx_par_bit;
      default:  tx_line = 1'b1;
    endcase
    tx_ready     = (tx_state == S_IDLE) && !rst;
    Tx_Active    = (tx_state != S_IDLE);
    Tx_Serial    = (rst || loopback) ? 1'b1 : tx_line;
    tx_state_dbg = tx_state;
  end

  // ---------------------------------------------------------------- RX
  state_t                 rx_state, rx_next;
  logic                   rx_sync1, rx_sync2, rx_prev;
  logic                   rx_src;
  logic [DIV_W-1:0]       rx_cnt;
  logic [IDX_W-1:0]       rx_idx;
  logic [DATA_BITS-1:0]   rx_shreg;
  logic                   rx_par_bit;
  logic                   rx_par_exp;
  logic                   rx_wait_high;
  logic                   rx_tick;
  logic                   rx_fall;

  assign rx_src     = loopback ? tx_line : Rx_Serial;
  assign rx_tick    = (rx_cnt == '0);
  assign rx_fall    = rx_prev & ~rx_sync2;
  assign rx_par_exp = (PARITY == 2) ? ~(^rx_shreg) : ^rx_shreg;

  // RX line synchroniser and edge-detect history (idle level is high)
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= rx_src;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
    end
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (rst) rx_state <= S_IDLE;
    else     rx_state <= rx_next;
  end

  // RX next-state: a high START sample is treated as a glitch
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:   if (!rx_wait_high && rx_fall) rx_next = S_START;
      S_START:  if (rx_tick) rx_next = rx_sync2 ? S_IDLE : S_DATA;
      S_DATA:   if (rx_tick && rx_idx == LAST_IDX)
                  rx_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (rx_tick) rx_next = S_STOP;
      S_STOP:   if (rx_tick) rx_next = S_IDLE;
      default:  rx_next = S_IDLE;
    endcase
  end

  // RX datapath: mid-bit sampling, shift-in, delivery and error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shreg      <= '0;
      rx_par_bit    <= 1'b0;
      rx_wait_high  <= 1'b0;
      Rx_Data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      if (rx_state == S_IDLE) begin
        rx_idx <= '0;
        if (rx_wait_high && rx_sync2) rx_wait_high <= 1'b0;
        if (!rx_wait_high && rx_fall) rx_cnt <= clk_div >> 1;
      end else if (rx_tick) begin
        rx_cnt <= clk_div;
        case (rx_state)
          S_DATA: begin
            rx_shreg <= {rx_sync2, rx_shreg[DATA_BITS-1:1]};
            rx_idx   <= rx_idx + 1'b1;
          end
          S_PARITY: rx_par_bit <= rx_sync2;
          S_STOP: begin
            Rx_Data       <= rx_shreg;
            rx_valid      <= 1'b1;
            rx_frame_err  <= ~rx_sync2;
            rx_parity_err <= (PARITY != 0) && (rx_par_bit != rx_par_exp);
            rx_wait_high  <= ~rx_sync2;
          end
          default: ;
        endcase
      end else begin
        rx_cnt <= rx_cnt - 1'b1;
      end
    end
  end

  // RX debug state view
  always_comb begin
    rx_state_dbg = rx_state;
  end

endmodule
